// File: rtl/key_debouncer_multi.sv
// rtl/key_debouncer_multi.sv - N-channel push-button synchroniser, debouncer and auto-repeat generator
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous reset, active-high
//   key_in        raw asynchronous button levels (polarity set by ACTIVE_LOW)
//   key_state     debounced level per channel, 1 = pressed
//   press_pulse   one-cycle pulse in the first cycle key_state reads 1
//   release_pulse one-cycle pulse in the first cycle key_state reads 0
//   repeat_pulse  one-cycle auto-repeat ticks while held (0 when REPEAT_EN=0)
//   any_pressed   registered OR of key_state
module key_debouncer_multi #(
    parameter int N               = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int HOLD_W          = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_in,
    output logic [N-1:0] key_state,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] repeat_pulse,
    output logic         any_pressed
);

    // Raw level of a key that is not pressed.
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Hold counters compare against limit-1 so the tick lands exactly
    // REPEAT_DELAY / REPEAT_RATE edges after the previous reference point.
    localparam logic [HOLD_W-1:0] DELAY_MAX = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_MAX  = HOLD_W'(REPEAT_RATE - 1);
    localparam logic              RPT_ON    = (REPEAT_EN != 0);

    // Repeat phase encoding.
    localparam logic [0:0] PH_DELAY = 1'b0;
    localparam logic [0:0] PH_RATE  = 1'b1;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] p;        // normalised sample, 1 = pressed
    logic [N-1:0] ks_nxt;   // key_state value being loaded this edge

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= {N{REL_LVL}};
            sync2 <= {N{REL_LVL}};
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign p = sync2 ^ {N{REL_LVL}};

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic              ks_q;
        logic              press_q;
        logic              release_q;
        logic              accept;
        logic [HOLD_W-1:0] hold;
        logic [0:0]        phase;
        logic              rep_q;
        logic [HOLD_W-1:0] limit;
        logic              rise;

        assign accept    = (p[i] != ks_q) && (cnt == CNT_MAX);
        assign ks_nxt[i] = accept ? p[i] : ks_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt       <= '0;
                ks_q      <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else if (p[i] == ks_q) begin
                // Back at the accepted level: any partial run is discarded.
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else if (cnt == CNT_MAX) begin
                ks_q      <= p[i];
                cnt       <= '0;
                press_q   <= p[i];
                release_q <= ~p[i];
            end else begin
                cnt       <= cnt + CNT_W'(1);
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end
        end

        assign rise  = ks_nxt[i] & ~ks_q;
        assign limit = (phase == PH_DELAY) ? DELAY_MAX : RATE_MAX;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold  <= '0;
                phase <= PH_DELAY;
                rep_q <= 1'b0;
            end else if (rise) begin
                hold  <= '0;
                phase <= PH_DELAY;
                rep_q <= 1'b0;
            end else if (ks_q && ks_nxt[i]) begin
                if (hold == limit) begin
                    hold  <= '0;
                    phase <= PH_RATE;
                    rep_q <= RPT_ON;
                end else begin
                    hold  <= hold + HOLD_W'(1);
                    rep_q <= 1'b0;
                end
            end else begin
                // Released or releasing this edge: a due tick is suppressed.
                hold  <= '0;
                phase <= PH_DELAY;
                rep_q <= 1'b0;
            end
        end

        assign key_state[i]     = ks_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = rep_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |ks_nxt;
        end
    end

endmodule

// File: doc/key_debouncer_multi.md
Name: key_debouncer_multi

Overview:
- Parametrised N-channel push-button conditioner; successor to the single-edge debouncer.
- Per channel: synchroniser, polarity normalisation, an independent debounce counter and a stable state.
- Emits one-cycle press, release and auto-repeat pulses plus a level state.
- Sits between board buttons and the single-cycle CPU debug/step logic (single-step, mode select, display paging).

Parameters:
N, 4, number of independent key channels
ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
DEBOUNCE_CYCLES, 2000000, consecutive cycles a new level must persist before acceptance (20 ms at 100 MHz); legal range >= 2
CNT_W, 21, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1
REPEAT_EN, 0, 1 enables auto-repeat pulses while held
REPEAT_DELAY, 50000000, cycles from accepted press to first repeat pulse (>= 1)
REPEAT_RATE, 10000000, cycles between subsequent repeat pulses (>= 1)
HOLD_W, 27, hold counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
key_in  input  N  raw asynchronous button levels
key_state  output  N  debounced level, 1 = pressed (polarity-normalised)
press_pulse  output  N  one-cycle high on accepted press
release_pulse  output  N  one-cycle high on accepted release
repeat_pulse  output  N  one-cycle high per auto-repeat tick; constant 0 when REPEAT_EN=0
any_pressed  output  1  OR of key_state

Behaviour:
- Reset (rst=1 at a clk edge): both synchroniser stages load the released raw level (ACTIVE_LOW ? 1 : 0). key_state, all pulses, any_pressed and all counters go to 0.
- Synchroniser: two flops per channel. The normalised sample is p = ACTIVE_LOW ? ~sync2 : sync2.
- Debounce, per channel, each edge:
  - if p == key_state: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: key_state <= p, cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: let E be the first edge at which sync1 captures a new level held constant. key_state changes at edge E+1+DEBOUNCE_CYCLES.
- Glitch rejection: any return to the old level before acceptance clears cnt; no state change, no pulse.
- Pulses are registered and asserted for exactly one cycle:
  - press_pulse is high in the same cycle key_state first reads 1.
  - release_pulse is high in the same cycle key_state first reads 0.
  - Press and release can never coincide on one channel.
- Auto-repeat (REPEAT_EN=1):
  - Let P be the edge at which key_state rises. At P, hold <= 0 and phase <= DELAY. Each later edge while key_state=1, hold increments.
  - When hold reaches the phase limit (REPEAT_DELAY for DELAY, REPEAT_RATE for RATE): repeat_pulse=1 for one cycle, hold <= 0, phase <= RATE.
  - Repeat pulses therefore land at P+REPEAT_DELAY, then every REPEAT_RATE cycles.
  - At the edge key_state falls, hold and phase are cleared and repeat_pulse is forced 0, even if a tick was due.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- Reset mid-count or mid-hold: all progress is discarded and no pulse is emitted. If a key is still pressed after reset deasserts, it is treated as a new press: press_pulse fires after the normal debounce latency.
- any_pressed is registered, equal to the OR of the key_state values driven in that cycle.
- Counters never wrap: cnt is bounded by DEBOUNCE_CYCLES-1 and hold by the phase limit.

Test Plan:
All scenarios use N=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_RATE=5.
- Clean press: key_in[0] 1->0, first captured at edge E -> key_state[0]=1 and press_pulse[0]=1 at E+9 only; any_pressed=1 from E+9.
- Glitches: key_in[0] low for 7 edges then high, repeated 5 times -> key_state, press_pulse, release_pulse all stay 0.
- Hold and repeat: press held 40 cycles after acceptance at P -> repeat_pulse[0] at P+20, P+25, P+30, P+35 only. Releasing so that key_state falls at P+35 -> release_pulse there and no repeat_pulse in that cycle.
- Independent channels: ch0 and ch1 pressed on the same edge -> both press_pulse bits in the same cycle. ch1 bouncing during ch0 hold -> ch0 repeat timing is unchanged.
- Reset mid-operation: rst asserted during cnt=5, key still low -> no pulse while in reset. After rst deasserts, press_pulse fires 9 edges after the first post-reset sync1 capture.
- Polarity: rerun the clean-press scenario with ACTIVE_LOW=0 and key_in 0->1 -> identical output timing.
